// File: rtl/tile_gfx_pkg.sv
// Shared tile-graphics constants (origins, colours, tile size) and the
// tile scheduler state encoding, reused by the other graphics blocks.
package tile_gfx_pkg;

   localparam int TILE_PIXELS = 64;

   localparam logic [7:0] TILE_X [0:3] = '{8'd40, 8'd88, 8'd40, 8'd88};
   localparam logic [6:0] TILE_Y [0:3] = '{7'd20, 7'd20, 7'd68, 7'd68};

   localparam logic [2:0] BASE_COLOUR [0:3] = '{3'b100, 3'b010, 3'b001, 3'b110};
   localparam logic [2:0] FLASH_COLOUR      = 3'b111;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      PAINT,
      HOLD,
      RESTORE,
      DONE
   } sched_state_t;

endpackage

// File: rtl/tile_cmd_fifo.sv
// Synchronous command FIFO for the tile scheduler; pushes while full and
// pops while empty are ignored.
module tile_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 29
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           wr_data,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CW'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // NOTE: storage is not reset; count and pointers alone define which entries are valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + CW'(1);
         else if (do_pop && !do_push) count <= count - CW'(1);
      end
   end

endmodule

// File: rtl/tile_flash_scheduler.sv
// Command-driven tile painter: queues draw/flash commands and drives the
// VGA pixel-write port with 64 plots per tile, plus hold and restore for flashes.
module tile_flash_scheduler
   import tile_gfx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int HOLD_W     = 26
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_tile,
   input  logic              cmd_flash,
   input  logic [HOLD_W-1:0] cmd_hold,
   output logic              plot,
   output logic [7:0]        x,
   output logic [6:0]        y,
   output logic [2:0]        colour,
   output logic              done,
   output logic              busy
);

   localparam int          DW       = 2 + 1 + HOLD_W;
   localparam logic [5:0]  LAST_PIX = 6'(TILE_PIXELS - 1);

   logic                      fifo_full;
   logic                      fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [DW-1:0]             fifo_head;
   logic                      push;
   logic                      pop;

   sched_state_t      state, state_d;
   logic [5:0]        pix, pix_d;
   logic [HOLD_W-1:0] hold_cnt, hold_cnt_d;
   logic [1:0]        tile, tile_d;
   logic              flash, flash_d;

   logic              plot_d;
   logic [7:0]        x_d;
   logic [6:0]        y_d;
   logic [2:0]        colour_d;

   assign cmd_ready = !reset && !fifo_full;
   assign push      = cmd_valid && cmd_ready;
   assign busy      = (state != IDLE) || (fifo_count != '0);

   tile_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DW)
   ) u_fifo (
      .clock   (clock),
      .reset   (reset),
      .push    (push),
      .pop     (pop),
      .wr_data ({cmd_tile, cmd_flash, cmd_hold}),
      .rd_data (fifo_head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // NOTE: every signal gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d    = state;
      pix_d      = pix;
      hold_cnt_d = hold_cnt;
      tile_d     = tile;
      flash_d    = flash;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            if (!fifo_empty) state_d = FETCH;
         end
         FETCH: begin
            // The hold counter is loaded here; it stays untouched until HOLD.
            pop                              = 1'b1;
            {tile_d, flash_d, hold_cnt_d}    = fifo_head;
            pix_d                            = '0;
            state_d                          = PAINT;
         end
         PAINT: begin
            pix_d = pix + 6'd1;
            if (pix == LAST_PIX) state_d = flash ? HOLD : DONE;
         end
         HOLD: begin
            if (hold_cnt == '0) begin
               pix_d   = '0;
               state_d = RESTORE;
            end else begin
               hold_cnt_d = hold_cnt - HOLD_W'(1);
            end
         end
         RESTORE: begin
            pix_d = pix + 6'd1;
            if (pix == LAST_PIX) state_d = DONE;
         end
         DONE: begin
            state_d = fifo_empty ? IDLE : FETCH;
         end
         default: state_d = IDLE;
      endcase
   end

   // Pixel outputs are derived from the next state so they register alongside it.
   always_comb begin
      plot_d   = (state_d == PAINT) || (state_d == RESTORE);
      colour_d = ((state_d == PAINT) && flash_d) ? FLASH_COLOUR : BASE_COLOUR[tile_d];
      x_d      = TILE_X[tile_d] + {5'd0, pix_d[2:0]};
      y_d      = TILE_Y[tile_d] + {4'd0, pix_d[5:3]};
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         pix      <= '0;
         hold_cnt <= '0;
         tile     <= '0;
         flash    <= 1'b0;
         plot     <= 1'b0;
         x        <= '0;
         y        <= '0;
         colour   <= '0;
         done     <= 1'b0;
      end else begin
         state    <= state_d;
         pix      <= pix_d;
         hold_cnt <= hold_cnt_d;
         tile     <= tile_d;
         flash    <= flash_d;
         plot     <= plot_d;
         done     <= (state_d == DONE);
         if (plot_d) begin
            x      <= x_d;
            y      <= y_d;
            colour <= colour_d;
         end
      end
   end

endmodule

// File: tb/tb_tile_flash_scheduler.sv
// Bench for tile_flash_scheduler: directed vector table, hand-written corner
// sequences (full FIFO during a long hold, reset mid-paint), randomized commands.
module tb_tile_flash_scheduler;

   localparam int FIFO_DEPTH = 4;
   localparam int HOLD_W     = 26;
   localparam int N_RAND     = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_tile;
   logic              cmd_flash;
   logic [HOLD_W-1:0] cmd_hold;
   logic              plot;
   logic [7:0]        x;
   logic [6:0]        y;
   logic [2:0]        colour;
   logic              done;
   logic              busy;

   int tests     = 0;
   int fails     = 0;
   int cyc       = 0;
   int done_seen = 0;

   typedef struct {
      logic [1:0] tile;
      logic       flash;
      int         hold;
      int         x0;
      int         y0;
      int         paint_col;
      int         restore_col;
   } vec_t;

   typedef struct {
      logic [1:0] tile;
      logic       flash;
      int         hold;
      int         acc_edge;
   } rec_t;

   rec_t acc_q [$];

   tile_flash_scheduler #(
      .FIFO_DEPTH (FIFO_DEPTH),
      .HOLD_W     (HOLD_W)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_tile  (cmd_tile),
      .cmd_flash (cmd_flash),
      .cmd_hold  (cmd_hold),
      .plot      (plot),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .done      (done),
      .busy      (busy)
   );

   always #5 clock = ~clock;

   // Edge index and done-pulse tally; done is read before the DUT updates it.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (done === 1'b1) done_seen <= done_seen + 1;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit, expected summary before it");
      $fatal(1, "watchdog");
   end

   // Behavioural tile geometry taken straight from the tile table.
   function automatic int ref_x0(input logic [1:0] t);
      return t[0] ? 88 : 40;
   endfunction

   function automatic int ref_y0(input logic [1:0] t);
      return t[1] ? 68 : 20;
   endfunction

   function automatic int ref_base(input logic [1:0] t);
      case (t)
         2'd0:    return 4;
         2'd1:    return 2;
         2'd2:    return 1;
         default: return 6;
      endcase
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input logic [1:0] t, input logic f, input int h);
      int w;
      w = 0;
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_tile  = t;
      cmd_flash = f;
      cmd_hold  = HOLD_W'(h);
      while (cmd_ready !== 1'b1 && w < 2000) begin
         @(negedge clock);
         w++;
      end
      if (cmd_ready !== 1'b1) check("push_ready_timeout", 0, 1);
      @(posedge clock);
      #1;
      cmd_valid = 1'b0;
   endtask

   // Waits for the next plot run, checks the non-plot gap before it (unless
   // lat_exp < 0) and the 64 row-major pixels of one tile pass.
   task automatic paint_phase(input string nm, input int x0, input int y0, input int col,
                              input int lat_exp, output int first_cyc);
      int lat;
      int bad;
      lat = 0;
      bad = 0;
      first_cyc = -1;
      @(negedge clock);
      while (plot !== 1'b1 && lat < 5000) begin
         lat++;
         @(negedge clock);
      end
      if (plot !== 1'b1) begin
         check({nm, "_timeout"}, 0, 1);
         return;
      end
      first_cyc = cyc;
      if (lat_exp >= 0) check({nm, "_gap"}, lat, lat_exp);
      for (int p = 0; p < 64; p++) begin
         if (p > 0) @(negedge clock);
         if (plot !== 1'b1 || done !== 1'b0 || x !== 8'(x0 + p % 8) ||
             y !== 7'(y0 + p / 8) || colour !== 3'(col)) bad++;
      end
      check({nm, "_pixels_bad"}, bad, 0);
   endtask

   task automatic done_phase(input string nm, output int dcyc);
      @(negedge clock);
      dcyc = cyc;
      check({nm, "_done_noplot"}, {done, plot}, 2'b10);
   endtask

   initial begin
      vec_t vecs [5];
      int   f;
      int   d;
      int   d0;
      int   bad;
      int   accepted;
      logic [1:0] seq [6];

      vecs[0] = '{2'd2, 1'b0, 0,  40, 68, 1, 1};
      vecs[1] = '{2'd1, 1'b1, 10, 88, 20, 7, 2};
      vecs[2] = '{2'd1, 1'b1, 0,  88, 20, 7, 2};
      vecs[3] = '{2'd0, 1'b0, 0,  40, 20, 4, 4};
      vecs[4] = '{2'd3, 1'b1, 3,  88, 68, 7, 6};

      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_tile  = '0;
      cmd_flash = 1'b0;
      cmd_hold  = '0;
      repeat (3) @(negedge clock);
      check("reset_outputs", {plot, x, y, colour, done, busy}, '0);
      check("reset_ready_low", cmd_ready, 0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", cmd_ready, 1);

      // Directed table: each vector starts from an idle scheduler.
      for (int i = 0; i < 5; i++) begin
         push(vecs[i].tile, vecs[i].flash, vecs[i].hold);
         paint_phase($sformatf("vec%0d_paint", i), vecs[i].x0, vecs[i].y0,
                     vecs[i].paint_col, 2, f);
         if (vecs[i].flash)
            paint_phase($sformatf("vec%0d_restore", i), vecs[i].x0, vecs[i].y0,
                        vecs[i].restore_col, vecs[i].hold + 1, f);
         done_phase($sformatf("vec%0d", i), d);
         check($sformatf("vec%0d_busy_in_done", i), busy, 1);
         @(negedge clock);
         check($sformatf("vec%0d_after_done", i), {done, busy}, 2'b00);
      end

      // Fill the FIFO during a long hold, then drain in order.
      seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      d0 = done_seen;
      push(2'd2, 1'b1, 1000);
      paint_phase("full_paint", 40, 68, 7, 2, f);
      accepted = 0;
      bad = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         cmd_valid = 1'b1;
         cmd_tile  = seq[i];
         cmd_flash = 1'b0;
         cmd_hold  = '0;
         if (cmd_ready === 1'b1) accepted++;
         if (plot !== 1'b0) bad++;
      end
      @(negedge clock);
      cmd_valid = 1'b0;
      check("full_accepted", accepted, 4);
      check("full_ready_low", cmd_ready, 0);
      check("full_hold_plot", bad, 0);
      paint_phase("full_restore", 40, 68, 1, 994, f);
      done_phase("full_first", d);
      for (int k = 0; k < 4; k++) begin
         paint_phase($sformatf("queued%0d", k), ref_x0(2'(k)), ref_y0(2'(k)),
                     ref_base(2'(k)), 1, f);
         done_phase($sformatf("queued%0d", k), d);
      end
      @(negedge clock);
      check("full_busy_end", busy, 0);
      check("full_done_count", done_seen - d0, 5);
      check("full_ready_end", cmd_ready, 1);

      // Reset in the middle of a paint with two commands still queued.
      push(2'd0, 1'b0, 0);
      push(2'd1, 1'b0, 0);
      push(2'd2, 1'b0, 0);
      bad = 0;
      @(negedge clock);
      while (plot !== 1'b1 && bad < 50) begin
         @(negedge clock);
         bad++;
      end
      repeat (30) @(negedge clock);
      check("pix30_xy", {x, y}, {8'd46, 7'd23});
      check("pix30_busy", busy, 1);
      d0 = done_seen;
      reset = 1'b1;
      @(negedge clock);
      check("midreset_outputs", {plot, busy, done, cmd_ready}, 4'b0000);
      check("midreset_x", x, 0);
      reset = 1'b0;
      bad = 0;
      repeat (6) begin
         @(negedge clock);
         if (plot !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
      end
      check("midreset_idle", bad, 0);
      check("midreset_no_done", done_seen - d0, 0);
      push(2'd3, 1'b0, 0);
      paint_phase("post_reset", 88, 68, 6, 2, f);
      done_phase("post_reset", d);

      // Randomized commands against the behavioural model.
      repeat (3) @(negedge clock);
      d0 = done_seen;
      fork
         begin : drv
            for (int i = 0; i < N_RAND; i++) begin
               int   w;
               rec_t r;
               @(negedge clock);
               cmd_valid = 1'b0;
               cmd_tile  = 2'($urandom);
               cmd_flash = 1'($urandom);
               cmd_hold  = HOLD_W'($urandom);
               repeat ($urandom_range(0, 30)) @(negedge clock);
               r.tile  = 2'($urandom);
               r.flash = 1'($urandom);
               r.hold  = int'($urandom_range(0, 20));
               cmd_valid = 1'b1;
               cmd_tile  = r.tile;
               cmd_flash = r.flash;
               cmd_hold  = HOLD_W'(r.hold);
               w = 0;
               while (cmd_ready !== 1'b1 && w < 2000) begin
                  @(negedge clock);
                  w++;
               end
               if (cmd_ready !== 1'b1) begin
                  check("rand_ready_timeout", 0, 1);
                  break;
               end
               r.acc_edge = cyc + 1;
               acc_q.push_back(r);
            end
            @(negedge clock);
            cmd_valid = 1'b0;
            cmd_hold  = HOLD_W'($urandom);
         end
         begin : chk
            int last_done;
            last_done = 0;
            for (int n = 0; n < N_RAND; n++) begin
               rec_t c;
               int   w;
               int   fc;
               int   start_exp;
               w = 0;
               while (acc_q.size() == 0 && w < 3000) begin
                  @(negedge clock);
                  w++;
               end
               if (acc_q.size() == 0) begin
                  check("rand_cmd_timeout", 0, 1);
                  break;
               end
               c = acc_q.pop_front();
               start_exp = ((c.acc_edge > last_done) ? c.acc_edge : last_done) + 2;
               paint_phase("rand_paint", ref_x0(c.tile), ref_y0(c.tile),
                           c.flash ? 7 : ref_base(c.tile), -1, fc);
               check("rand_start_edge", fc, start_exp);
               if (c.flash)
                  paint_phase("rand_restore", ref_x0(c.tile), ref_y0(c.tile),
                              ref_base(c.tile), c.hold + 1, fc);
               done_phase("rand", last_done);
            end
         end
      join
      repeat (3) @(negedge clock);
      check("rand_busy_end", busy, 0);
      check("rand_done_count", done_seen - d0, N_RAND);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tile_flash_scheduler.md
Name: tile_flash_scheduler

Overview:
Command-driven sequencer for tile drawing into the VGA pixel-write port. The game FSM queues "draw tile N, optionally flash" commands instead of stepping pixel counters and delay counters itself. The block buffers commands in a small FIFO and, for each one, emits 64 pixel plots for the 8x8 tile. For flash commands it then holds the flash colour for a programmable time and redraws the tile in its base colour.

Parameters:
FIFO_DEPTH, 4, command FIFO entries (power of two, >= 2)
HOLD_W, 26, width of the hold-time field and hold counter (cycles)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO can accept; a push occurs on a clock edge where cmd_valid && cmd_ready
cmd_tile  in  2  tile index 0-3
cmd_flash  in  1  1 = flash then restore; 0 = plain draw in base colour
cmd_hold  in  HOLD_W  flash hold length in cycles
plot  out  1  VGA write enable
x  out  8  pixel x (160-wide screen)
y  out  7  pixel y (120-high screen)
colour  out  3  pixel RGB
done  out  1  one-cycle pulse when a command completes
busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Clock and reset: one clock `clock`; reset `reset` is synchronous and active-high.
- Reset values: plot=0, x=0, y=0, colour=0, done=0, busy=0, FIFO count=0, state=IDLE.
- cmd_ready is 0 while reset is high; otherwise cmd_ready = (count != FIFO_DEPTH).
- FIFO ordering and counting:
  - Strict in-order execution.
  - Push and pop on the same edge leave the count unchanged.
  - A push at count FIFO_DEPTH-1 with a same-edge pop is legal.
  - No push is possible while full.
- Tile geometry (from the shared package):
  - Origins: tile0 (40,20), tile1 (88,20), tile2 (40,68), tile3 (88,68).
  - Base colours: 100, 010, 001, 110.
  - FLASH colour: 111.
- Pixel counter pix is 6 bits:
  - x = org_x + pix[2:0], y = org_y + pix[5:3].
  - Counts 0..63; exit from a paint state happens on pix==63, which wraps pix to 0.
- FSM states:
  - IDLE: if FIFO non-empty -> FETCH.
  - FETCH: pop FIFO; latch tile, flash, hold into working registers; pix=0 -> PAINT.
  - PAINT: plot=1 for exactly 64 cycles. colour = flash ? FLASH : base. At pix==63: flash -> HOLD (load hold counter with latched hold); else -> DONE.
  - HOLD: plot=0; if counter==0 -> RESTORE (pix=0), else decrement. Occupies hold+1 cycles (hold=0 gives 1 cycle).
  - RESTORE: plot=1, colour=base, 64 cycles; at pix==63 -> DONE.
  - DONE: done=1 for this cycle only. FIFO non-empty -> FETCH, else -> IDLE.
- Output registering:
  - x, y, colour and plot are registered together, so x/y/colour never change during a cycle with plot=1 that belongs to a different pixel.
  - x, y and colour hold their last values when plot=0.
- Latency:
  - Push into an empty FIFO while IDLE: FETCH is the next cycle, and the first plot cycle starts 2 cycles after the accepting edge.
  - Plain command: 64 plot cycles, then done.
  - Back-to-back commands: DONE -> FETCH -> PAINT, so there are 2 non-plot cycles between commands.
- Reset mid-operation:
  - The next edge returns to IDLE and drops plot.
  - The FIFO is emptied and no done pulse is emitted.
  - Any partially drawn tile is left on screen as-is.
- cmd_tile, cmd_flash and cmd_hold are sampled only at push. Changes after push have no effect.

Decomposition:
- Shared package tile_gfx_pkg:
  - Tile origin constants TILE_X[0:3], TILE_Y[0:3].
  - BASE_COLOUR[0:3] and FLASH_COLOUR.
  - TILE_PIXELS=64.
  - FSM state encoding (IDLE, FETCH, PAINT, HOLD, RESTORE, DONE).
  - The graphics controller and score renderer reuse these constants.
- One sub-module: tile_cmd_fifo, a synchronous FIFO of width 2+1+HOLD_W with depth FIFO_DEPTH, outputs full/empty/count, and same synchronous active-high reset.

Test Plan:
1. Reset, push {tile=2, flash=0} -> 64 plot cycles covering x 40..47, y 68..75 row-major with colour 001; then done pulses once; busy falls the following cycle.
2. Push {tile=1, flash=1, hold=10} -> 64 plots colour 111 at x 88..95, y 20..27; then 11 cycles with plot=0; then 64 plots colour 010; then a single done pulse.
3. Push a flash command with hold=0 -> exactly 1 non-plot cycle between the last 111 plot and the first 010 plot.
4. During a flash with hold=1000, hold cmd_valid high for 6 cycles with tiles 0,1,2,3,0,1 -> first 4 accepted and cmd_ready low after them. Queued tiles then execute in order 0,1,2,3 with 2 non-plot cycles between commands; done pulses 5 times total.
5. Assert reset when pix=30 of PAINT with 2 commands queued -> plot=0 on the next cycle, busy=0, no done pulse. A new push afterwards starts from pix 0 with first plot 2 cycles after the accepting edge.
